phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer_pkg.sv | 11 +
 rtl/phase_sequencer_if.sv | 31 +++
 rtl/phase_sequencer_dwell_counter.sv | 27 ++
 rtl/phase_sequencer.sv | 97 +++++++++
 tb/tb_phase_sequencer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared types and constants for the phase sequencer.
package phase_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int STRIKE_CNT_W = 8;

endpackage

// File: rtl/phase_sequencer_if.sv
// Control and status bundle between a sequencer host and the phase sequencer.
import phase_sequencer_pkg::*;

interface phase_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int DWELL_W    = 4,
  parameter int HEIGHT_W   = 5
);
  localparam int PH_W = $clog2(NUM_PHASES);

  logic [HEIGHT_W-1:0]     height;
  logic                    strike;
  logic                    hold;
  logic                    mode;
  logic [DWELL_W-1:0]      dwell;
  logic [NUM_PHASES-1:0]   en;
  logic [PH_W-1:0]         phase;
  logic                    busy;
  logic                    pass_done;
  logic [STRIKE_CNT_W-1:0] strike_cnt;

  modport master (
    output height, strike, hold, mode, dwell,
    input  en, phase, busy, pass_done, strike_cnt
  );

  modport slave (
    input  height, strike, hold, mode, dwell,
    output en, phase, busy, pass_done, strike_cnt
  );
endinterface

// File: rtl/phase_sequencer_dwell_counter.sv
// Per-phase dwell down-counter: loads on phase entry, decrements while
// enabled, and flags terminal count at zero.
module phase_dwell_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Load has priority over decrement; a held counter simply keeps its value.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/phase_sequencer.sv
// One-hot phase sequencer with per-phase dwell, hold, single/continuous
// pass modes and a saturating abort (strike) counter.
//
//   state | meaning
//   IDLE  | phase 0 parked, waiting for a nonzero height to arm
//   RUN   | stepping through phases, each lasting dwell+1 unheld cycles
import phase_sequencer_pkg::*;

module phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int DWELL_W    = 4,
  parameter int HEIGHT_W   = 5
) (
  input logic              clk,
  input logic              rst,
  phase_sequencer_if.slave bus
);
  localparam int PH_W = $clog2(NUM_PHASES);
  localparam logic [STRIKE_CNT_W-1:0] STRIKE_MAX = {STRIKE_CNT_W{1'b1}};
  localparam logic [PH_W-1:0]         LAST_PH    = PH_W'(NUM_PHASES - 1);

  state_t                  state;
  logic [PH_W-1:0]         phase_q;
  logic                    pass_done_q;
  logic [STRIKE_CNT_W-1:0] strike_cnt_q;

  logic               arm;
  logic               run_go;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [DWELL_W-1:0] cnt;

  // Counter control: load on arming or on a phase advance, else count down
  // whenever RUN is neither aborted nor held.
  always_comb begin
    arm      = (state == IDLE) && !bus.strike && (bus.height != '0);
    run_go   = (state == RUN) && !bus.strike && !bus.hold;
    cnt_load = arm || (run_go && cnt_zero);
    cnt_dec  = run_go && !cnt_zero;
  end

  phase_dwell_counter #(.W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (bus.dwell),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Sequencer FSM: strike beats hold beats advance; mode only matters at wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase_q      <= '0;
      pass_done_q  <= 1'b0;
      strike_cnt_q <= '0;
    end else begin
      pass_done_q <= 1'b0;
      if (bus.strike) begin
        if (strike_cnt_q != STRIKE_MAX)
          strike_cnt_q <= strike_cnt_q + 1'b1;
        state   <= IDLE;
        phase_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.height != '0)
              state <= RUN;
          end
          RUN: begin
            if (!bus.hold && cnt_zero) begin
              if (phase_q == LAST_PH) begin
                phase_q     <= '0;
                pass_done_q <= 1'b1;
                if (bus.mode)
                  state <= IDLE;
              end else begin
                phase_q <= phase_q + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.en         = NUM_PHASES'(1) << phase_q;
  assign bus.phase      = phase_q;
  assign bus.busy       = (state == RUN);
  assign bus.pass_done  = pass_done_q;
  assign bus.strike_cnt = strike_cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for the phase sequencer: a 4-phase instance for the main
// scenarios and a 6-phase instance for the wider rotation.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  phase_sequencer_if #(.NUM_PHASES(4), .DWELL_W(4), .HEIGHT_W(5)) ifa ();
  phase_sequencer_if #(.NUM_PHASES(6), .DWELL_W(4), .HEIGHT_W(5)) ifb ();

  phase_sequencer #(.NUM_PHASES(4), .DWELL_W(4), .HEIGHT_W(5)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  phase_sequencer #(.NUM_PHASES(6), .DWELL_W(4), .HEIGHT_W(5)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.height = '0; ifa.strike = 1'b0; ifa.hold = 1'b0; ifa.mode = 1'b0; ifa.dwell = '0;
    ifb.height = '0; ifb.strike = 1'b0; ifb.hold = 1'b0; ifb.mode = 1'b0; ifb.dwell = '0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    check("rst_en", ifa.en, 32'h1);
    check("rst_phase", ifa.phase, 32'h0);
    check("rst_busy", ifa.busy, 32'h0);
    check("rst_pd", ifa.pass_done, 32'h0);
    check("rst_scnt", ifa.strike_cnt, 32'h0);
    rst = 1'b0;

    // Hold in IDLE does nothing
    ifa.hold = 1'b1;
    tick();
    check("idle_hold_busy", ifa.busy, 32'h0);
    ifa.hold = 1'b0;

    // Continuous rotation, dwell 0
    ifa.dwell = 4'd0; ifa.mode = 1'b0; ifa.height = 5'd3;
    tick();
    ifa.height = '0;
    check("c0_busy", ifa.busy, 32'h1);
    check("c0_en", ifa.en, 32'h1);
    for (int c = 1; c <= 12; c++) begin
      tick();
      check("c0_walk_en", ifa.en, 32'h1 << (c % 4));
      check("c0_walk_pd", ifa.pass_done, (c % 4 == 0) ? 32'h1 : 32'h0);
    end
    // now in phase 0; step to phase 3, then strike
    tick(); tick(); tick();
    check("pre_strike_en", ifa.en, 32'h8);
    ifa.strike = 1'b1;
    tick();
    ifa.strike = 1'b0;
    check("strike_en", ifa.en, 32'h1);
    check("strike_busy", ifa.busy, 32'h0);
    check("strike_cnt1", ifa.strike_cnt, 32'h1);
    check("strike_pd", ifa.pass_done, 32'h0);
    tick();
    check("strike_pd_after", ifa.pass_done, 32'h0);

    // Single pass, dwell 2
    ifa.dwell = 4'd2; ifa.mode = 1'b1; ifa.height = 5'd5;
    tick();
    ifa.height = '0;
    check("sp_busy", ifa.busy, 32'h1);
    check("sp_en0", ifa.en, 32'h1);
    for (int c = 1; c <= 12; c++) begin
      tick();
      check("sp_en", ifa.en, (c == 12) ? 32'h1 : (32'h1 << (c / 3)));
      check("sp_pd", ifa.pass_done, (c == 12) ? 32'h1 : 32'h0);
    end
    check("sp_end_busy", ifa.busy, 32'h0);
    tick();
    check("sp_idle_en", ifa.en, 32'h1);
    check("sp_idle_busy", ifa.busy, 32'h0);
    check("sp_idle_pd", ifa.pass_done, 32'h0);

    // Hold during phase 2, dwell 0
    ifa.dwell = 4'd0; ifa.mode = 1'b0; ifa.height = 5'd1;
    tick();
    ifa.height = '0;
    tick();
    tick();
    check("hold_entry_en", ifa.en, 32'h4);
    ifa.hold = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("hold_en", ifa.en, 32'h4);
    end
    ifa.hold = 1'b0;
    tick();
    check("hold_release_en", ifa.en, 32'h8);
    // height during RUN is ignored
    ifa.height = 5'd9;
    tick();
    check("run_height_en", ifa.en, 32'h1);
    check("run_height_busy", ifa.busy, 32'h1);
    ifa.height = '0;
    ifa.strike = 1'b1;
    tick();
    ifa.strike = 1'b0;
    check("strike_cnt2", ifa.strike_cnt, 32'h2);

    // Strike with height in IDLE: stays idle, then saturates
    ifa.strike = 1'b1; ifa.height = 5'd7;
    tick();
    check("idle_strike_busy", ifa.busy, 32'h0);
    check("idle_strike_cnt", ifa.strike_cnt, 32'h3);
    for (int c = 0; c < 252; c++) tick();
    check("sat_cnt_255", ifa.strike_cnt, 32'hFF);
    for (int c = 0; c < 10; c++) tick();
    check("sat_cnt_hold", ifa.strike_cnt, 32'hFF);
    check("sat_busy", ifa.busy, 32'h0);
    ifa.strike = 1'b0; ifa.height = '0;

    // Six phases, dwell 1, continuous
    ifb.dwell = 4'd1; ifb.mode = 1'b0; ifb.height = 5'd2;
    tick();
    ifb.height = '0;
    check("p6_en0", ifb.en, 32'h1);
    for (int c = 1; c <= 24; c++) begin
      tick();
      check("p6_en", ifb.en, 32'h1 << ((c / 2) % 6));
      check("p6_pd", ifb.pass_done, (c % 12 == 0) ? 32'h1 : 32'h0);
    end

    // Reset mid-RUN: no pass_done, back to idle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_run_busy", ifb.busy, 32'h0);
    check("rst_run_pd", ifb.pass_done, 32'h0);
    check("rst_run_en", ifb.en, 32'h1);
    check("rst_scnt_clr", ifa.strike_cnt, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
